tt_um_opamp_sar_ctrl: RTL and testbench



---
 rtl/tt_um_opamp_sar_ctrl.sv | 141 ++++++++++++++
 tb/tb_tt_um_opamp_sar_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/tt_um_opamp_sar_ctrl.sv
// Successive-approximation controller for the opamp tile.
// The controller tests one bit at a time, from the MSB down to the LSB. For each bit it
// drives a trial code to the DAC and waits SETTLE cycles for the DAC and the comparator
// to settle. It then keeps or clears that bit using the synchronized comparator decision.
module tt_um_opamp_sar_ctrl #(
    parameter int WIDTH  = 8,
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic             cmp_in,
    output logic [WIDTH-1:0] dac_code,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             result_valid
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_DECIDE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] dac_code_q, dac_code_d;
    logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             result_valid_q, result_valid_d;
    logic             cmp_meta_q;
    logic             cmp_s_q;

    // Two-flop synchronizer so that the asynchronous comparator output never reaches the FSM directly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_meta_q <= 1'b0;
            cmp_s_q    <= 1'b0;
        end else begin
            cmp_meta_q <= cmp_in;
            cmp_s_q    <= cmp_meta_q;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            dac_code_q     <= '0;
            bit_idx_q      <= '0;
            cnt_q          <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            dac_code_q     <= dac_code_d;
            bit_idx_q      <= bit_idx_d;
            cnt_q          <= cnt_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
        end
    end

    // Next-state logic: start a conversion, count down the settling time, then decide the current bit
    always_comb begin
        state_d        = state_q;
        dac_code_d     = dac_code_q;
        bit_idx_d      = bit_idx_q;
        cnt_d          = cnt_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        result_d       = result_q;
        result_valid_d = result_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (start && ena) begin
                    dac_code_d     = {1'b1, {(WIDTH-1){1'b0}}};
                    bit_idx_d      = IDX_W'(WIDTH - 1);
                    cnt_d          = CNT_W'(SETTLE - 1);
                    busy_d         = 1'b1;
                    result_valid_d = 1'b0;
                    state_d        = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (!ena) begin
                    dac_code_d = '0;
                    busy_d     = 1'b0;
                    state_d    = ST_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = ST_DECIDE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DECIDE: begin
                if (!ena) begin
                    dac_code_d = '0;
                    busy_d     = 1'b0;
                    state_d    = ST_IDLE;
                end else begin
                    dac_code_d[bit_idx_q] = cmp_s_q;
                    if (bit_idx_q != '0) begin
                        dac_code_d[bit_idx_q - IDX_W'(1)] = 1'b1;
                        bit_idx_d = bit_idx_q - IDX_W'(1);
                        cnt_d     = CNT_W'(SETTLE - 1);
                        state_d   = ST_SETTLE;
                    end else begin
                        result_d       = dac_code_d;
                        done_d         = 1'b1;
                        result_valid_d = 1'b1;
                        busy_d         = 1'b0;
                        state_d        = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign dac_code     = dac_code_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;

endmodule

// File: tb/tb_tt_um_opamp_sar_ctrl.sv
// Testbench for tt_um_opamp_sar_ctrl.
// A table of comparator setups drives a set of complete conversions. A scoreboard queue
// holds the expected results and a monitor compares them against every done pulse.
// Hand-written sequences cover the DAC trial order, a restart while busy, an abort
// through ena, and an asynchronous reset.
module tb_tt_um_opamp_sar_ctrl;

    localparam int WIDTH   = 8;
    localparam int SETTLE  = 2;
    localparam int LATENCY = WIDTH * (SETTLE + 1);

    typedef struct {
        logic [1:0] mode;       // 0: tied low, 1: tied high, 2: comparator model
        logic [7:0] vin;
        logic [7:0] exp_result;
    } vec_t;

    logic             clk;
    logic             rst_n;
    logic             ena;
    logic             start;
    logic             cmp_in;
    logic [WIDTH-1:0] dac_code;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             result_valid;

    logic [1:0]       cmp_mode;
    logic [7:0]       cmp_vin;
    logic [7:0]       exp_q[$];
    int               checks;
    int               errors;

    tt_um_opamp_sar_ctrl #(.WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .start        (start),
        .cmp_in       (cmp_in),
        .dac_code     (dac_code),
        .busy         (busy),
        .done         (done),
        .result       (result),
        .result_valid (result_valid)
    );

    // Comparator model: either tied to a constant, or an ideal comparator of Vin against the DAC code
    assign cmp_in = (cmp_mode == 2'd0) ? 1'b0 :
                    (cmp_mode == 2'd1) ? 1'b1 : (dac_code <= cmp_vin);

    // Free-running tile clock with a 10 time-unit period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so that the run always ends even if the bench itself gets stuck
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Starts a conversion. The caller is at a negedge. When push is set, the expected
    // result goes onto the scoreboard. The task returns at the negedge right after the
    // accepting edge.
    task automatic applyStimulus(input logic [1:0] mode, input logic [7:0] vin,
                                 input logic [7:0] exp_res, input bit push);
        cmp_mode = mode;
        cmp_vin  = vin;
        if (push) exp_q.push_back(exp_res);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits a bounded number of cycles for done. The task returns the cycle index at
    // which done was seen.
    task automatic waitDone(input int n0, output int n);
        n = n0;
        while (n < n0 + 60) begin
            @(negedge clk);
            n++;
            if (done) break;
        end
        if (!done) checkOutput("done_timeout", 32'd0, 32'd1);
    endtask

    // Scoreboard monitor: every done pulse must match the oldest expected result
    always @(negedge clk) begin
        if (rst_n && done) begin
            checkOutput("done_while_busy", {31'd0, busy}, 32'd0);
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_done", 32'd1, 32'd0);
            end else begin
                checkOutput("result", {24'd0, result}, {24'd0, exp_q.pop_front()});
                checkOutput("result_valid", {31'd0, result_valid}, 32'd1);
            end
        end
    end

    vec_t       vecs[8];
    logic [7:0] trial_seq[8];
    int         n;

    initial begin
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b1;
        ena      = 1'b1;
        start    = 1'b0;
        cmp_mode = 2'd0;
        cmp_vin  = 8'h00;

        vecs[0] = '{2'd1, 8'h00, 8'hFF};
        vecs[1] = '{2'd0, 8'h00, 8'h00};
        vecs[2] = '{2'd2, 8'h5A, 8'h5A};
        vecs[3] = '{2'd2, 8'h00, 8'h00};
        vecs[4] = '{2'd2, 8'h01, 8'h01};
        vecs[5] = '{2'd2, 8'hFE, 8'hFE};
        vecs[6] = '{2'd2, 8'hFF, 8'hFF};
        vecs[7] = '{2'd2, 8'h96, 8'h96};

        trial_seq[0] = 8'h80; trial_seq[1] = 8'h40; trial_seq[2] = 8'h60; trial_seq[3] = 8'h50;
        trial_seq[4] = 8'h58; trial_seq[5] = 8'h5C; trial_seq[6] = 8'h5A; trial_seq[7] = 8'h5B;

        // Reset values
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_dac", {24'd0, dac_code}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_result", {24'd0, result}, 32'd0);
        checkOutput("rst_valid", {31'd0, result_valid}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table of complete conversions
        for (int v = 0; v < 8; v++) begin
            applyStimulus(vecs[v].mode, vecs[v].vin, vecs[v].exp_result, 1'b1);
            checkOutput("busy_start", {31'd0, busy}, 32'd1);
            checkOutput("valid_cleared", {31'd0, result_valid}, 32'd0);
            waitDone(0, n);
            checkOutput("latency", n, LATENCY);
            @(negedge clk);
            checkOutput("done_one_cycle", {31'd0, done}, 32'd0);
            checkOutput("idle_dac", {24'd0, dac_code}, {24'd0, vecs[v].exp_result});
            checkOutput("idle_busy", {31'd0, busy}, 32'd0);
        end

        // DAC trial sequence for Vin 0x5A: each trial code is held for three cycles
        applyStimulus(2'd2, 8'h5A, 8'h5A, 1'b1);
        for (int k = 0; k < LATENCY; k++) begin
            checkOutput("trial_code", {24'd0, dac_code}, {24'd0, trial_seq[k / 3]});
            if (k < LATENCY - 1) @(negedge clk);
        end
        waitDone(LATENCY - 1, n);
        checkOutput("latency_5a", n, LATENCY);
        @(negedge clk);

        // A second start in the middle of a conversion is ignored
        applyStimulus(2'd2, 8'hA7, 8'hA7, 1'b1);
        n = 0;
        while (n < 10) begin
            @(negedge clk);
            n++;
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n++;
        waitDone(n, n);
        checkOutput("latency_restart", n, LATENCY);
        repeat (30) @(negedge clk);
        checkOutput("no_restart_busy", {31'd0, busy}, 32'd0);

        // Abort through ena: no done pulse, and the previous result is kept
        applyStimulus(2'd2, 8'h33, 8'h33, 1'b0);
        n = 0;
        while (n < 12) begin
            @(negedge clk);
            n++;
        end
        ena = 1'b0;
        @(negedge clk);
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_dac", {24'd0, dac_code}, 32'd0);
        checkOutput("abort_done", {31'd0, done}, 32'd0);
        checkOutput("abort_result", {24'd0, result}, 32'hA7);
        checkOutput("abort_valid", {31'd0, result_valid}, 32'd0);

        // A start is ignored while ena is low in IDLE
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("ena_low_busy", {31'd0, busy}, 32'd0);
        ena = 1'b1;
        repeat (30) @(negedge clk);
        checkOutput("ena_low_idle", {31'd0, busy}, 32'd0);

        // Asynchronous reset in the middle of a conversion, applied between clock edges
        applyStimulus(2'd1, 8'h00, 8'hFF, 1'b1);
        waitDone(0, n);
        @(negedge clk);
        applyStimulus(2'd2, 8'h10, 8'h10, 1'b0);
        repeat (8) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_dac", {24'd0, dac_code}, 32'd0);
        checkOutput("arst_busy", {31'd0, busy}, 32'd0);
        checkOutput("arst_result", {24'd0, result}, 32'd0);
        checkOutput("arst_valid", {31'd0, result_valid}, 32'd0);
        checkOutput("arst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        checkOutput("arst_idle", {31'd0, busy}, 32'd0);
        checkOutput("scoreboard_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
